upower_ri_control: RTL

UPOWER_RI_CONTROL -- requirements
Module: upower_ri_control

---
 rtl/upower_pkg.sv | 34 +++
 rtl/upower_ri_decode.sv | 72 +++++++
 rtl/upower_ri_control.sv | 98 +++++++++
 3 files changed

// File: rtl/upower_pkg.sv
// Shared constants for the uPower R/I-type controller:
// opcodes, extended opcodes, ALU encodings, FSM states.
package upower_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_DECODE    = 2'd1,
      S_EXECUTE   = 2'd2,
      S_WRITEBACK = 2'd3
   } state_t;

   localparam logic [5:0] OP_ADDI = 6'd14;
   localparam logic [5:0] OP_ORI  = 6'd24;
   localparam logic [5:0] OP_ANDI = 6'd28;
   localparam logic [5:0] OP_EXT  = 6'd31;

   localparam logic [9:0] XO_AND  = 10'd28;
   localparam logic [9:0] XO_SUBF = 10'd40;
   localparam logic [9:0] XO_ADD  = 10'd266;
   localparam logic [9:0] XO_OR   = 10'd444;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src;
      logic       reg_dst;
      logic       xo;
   } ctrl_t;

endpackage

// File: rtl/upower_ri_decode.sv
// Combinational decoder: instruction word to datapath
// controls plus a legal flag. Rc (bit 0) is ignored.
module upower_ri_decode
   import upower_pkg::*;
(
   input  logic [31:0] instruction,
   output logic [3:0]  ALU_OP,
   output logic        ALUSrc,
   output logic        RegDst,
   output logic        XO,
   output logic        legal
);

   logic [5:0] w_opcode;
   logic [9:0] w_xo;
   ctrl_t      w_ctrl;
   logic       w_legal;
   logic       w_unused_bits;

   assign w_opcode      = instruction[31:26];
   assign w_xo          = instruction[10:1];
   assign w_unused_bits = ^{instruction[25:11], instruction[0]};

   // Map opcode (and extended opcode for op 31) to controls
   always_comb begin
      w_ctrl  = '0;
      w_legal = 1'b0;
      unique case (w_opcode)
         OP_EXT: begin
            unique case (w_xo)
               XO_ADD: begin
                  w_ctrl  = '{ALU_ADD, 1'b0, 1'b1, 1'b1};
                  w_legal = 1'b1;
               end
               XO_SUBF: begin
                  w_ctrl  = '{ALU_SUB, 1'b0, 1'b1, 1'b1};
                  w_legal = 1'b1;
               end
               XO_AND: begin
                  w_ctrl  = '{ALU_AND, 1'b0, 1'b1, 1'b0};
                  w_legal = 1'b1;
               end
               XO_OR: begin
                  w_ctrl  = '{ALU_OR, 1'b0, 1'b1, 1'b0};
                  w_legal = 1'b1;
               end
               default: ;
            endcase
         end
         OP_ADDI: begin
            w_ctrl  = '{ALU_ADD, 1'b1, 1'b0, 1'b1};
            w_legal = 1'b1;
         end
         OP_ANDI: begin
            w_ctrl  = '{ALU_AND, 1'b1, 1'b0, 1'b0};
            w_legal = 1'b1;
         end
         OP_ORI: begin
            w_ctrl  = '{ALU_OR, 1'b1, 1'b0, 1'b0};
            w_legal = 1'b1;
         end
         default: ;
      endcase
   end

   assign ALU_OP = w_ctrl.alu_op;
   assign ALUSrc = w_ctrl.alu_src;
   assign RegDst = w_ctrl.reg_dst;
   assign XO     = w_ctrl.xo;
   assign legal  = w_legal;

endmodule

// File: rtl/upower_ri_control.sv
// Four-state uPower R/I-type controller: latch, decode,
// execute, write back; illegal encodings are rejected.
module upower_ri_control
   import upower_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [31:0] instruction,
   output logic        instr_ready,
   output logic [3:0]  ALU_OP,
   output logic        RegWrite,
   output logic        RegDst,
   output logic        ALUSrc,
   output logic        XO,
   output logic        done,
   output logic        illegal
);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_instr;
   logic        r_illegal;
   logic        w_ready;
   logic [3:0]  w_dec_alu;
   logic        w_dec_src;
   logic        w_dec_dst;
   logic        w_dec_xo;
   logic        w_dec_legal;

   upower_ri_decode u_decode (
      .instruction (r_instr),
      .ALU_OP      (w_dec_alu),
      .ALUSrc      (w_dec_src),
      .RegDst      (w_dec_dst),
      .XO          (w_dec_xo),
      .legal       (w_dec_legal)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Latch the word on handshake; flag rejects for one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr   <= '0;
         r_illegal <= 1'b0;
      end else begin
         if (instr_valid && w_ready) r_instr <= instruction;
         r_illegal <= (r_state == S_DECODE) && !w_dec_legal;
      end
   end

   // Next state and state-gated control outputs
   always_comb begin
      w_next   = r_state;
      w_ready  = 1'b0;
      ALU_OP   = '0;
      ALUSrc   = 1'b0;
      RegDst   = 1'b0;
      XO       = 1'b0;
      RegWrite = 1'b0;
      done     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_ready = !rst;
            if (instr_valid && !rst) w_next = S_DECODE;
         end
         S_DECODE: begin
            w_next = w_dec_legal ? S_EXECUTE : S_IDLE;
         end
         S_EXECUTE: begin
            ALU_OP = w_dec_alu;
            ALUSrc = w_dec_src;
            RegDst = w_dec_dst;
            XO     = w_dec_xo;
            w_next = S_WRITEBACK;
         end
         S_WRITEBACK: begin
            ALU_OP   = w_dec_alu;
            ALUSrc   = w_dec_src;
            RegDst   = w_dec_dst;
            XO       = w_dec_xo;
            RegWrite = 1'b1;
            done     = 1'b1;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign instr_ready = w_ready;
   assign illegal     = r_illegal;

endmodule
